// File: rtl/beat_interval_logger_pkg.sv
// rtl/beat_interval_logger_pkg.sv - shared defaults and FSM state type for the beat interval logger
package beat_interval_logger_pkg;

    localparam int BIL_DATA_W          = 8;
    localparam int BIL_ADDR_W          = 3;
    localparam int BIL_REFRACT_SAMPLES = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_LOW  = 2'd2,
        ST_HIGH = 2'd3
    } bil_state_t;

endpackage

// File: rtl/beat_interval_logger_sat_counter.sv
// rtl/beat_interval_logger_sat_counter.sv - saturating counter, up mode sticks at all-ones, down mode at zero
module beat_interval_logger_sat_counter #(
    parameter int W    = 8,
    parameter bit DOWN = 1'b0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         step_i,
    output logic [W-1:0] value_o
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (load_i) begin
            value_d = load_val_i;
        end else if (step_i) begin
            if (DOWN) begin
                if (value_q != '0) value_d = value_q - ONE;
            end else begin
                if (value_q != MAX) value_d = value_q + ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value_o = value_q;

endmodule

// File: rtl/beat_interval_logger.sv
// rtl/beat_interval_logger.sv - hysteresis beat detector writing beat-to-beat intervals into an 8-entry circular register-file log
// Optional refractory suppression of early beats is built when BEAT_REFRACTORY_EN is defined.
module beat_interval_logger
    import beat_interval_logger_pkg::*;
#(
    parameter int DATA_W          = BIL_DATA_W,
    parameter int ADDR_W          = BIL_ADDR_W,
    parameter int REFRACT_SAMPLES = BIL_REFRACT_SAMPLES
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [DATA_W-1:0] SAMPLE,
    input  logic              SAMPLE_VLD,
    input  logic [DATA_W-1:0] THRESH_HI,
    input  logic [DATA_W-1:0] THRESH_LO,
    output logic [ADDR_W-1:0] DR,
    output logic              LD,
    output logic [DATA_W-1:0] D_OUT,
    output logic              BEAT,
    output logic [ADDR_W:0]   LOG_CNT,
    output logic              OVF
);

    localparam logic [DATA_W-1:0] INTERVAL_MAX = '1;
    localparam logic [DATA_W-1:0] DATA_ONE     = DATA_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE      = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LOG_DEPTH    = {1'b1, {ADDR_W{1'b0}}};

    bil_state_t        state_q, state_d;
    logic              have_prev_q;
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W-1:0] dr_q;
    logic              ld_q;
    logic [DATA_W-1:0] dout_q;
    logic              beat_q;
    logic [ADDR_W:0]   log_cnt_q;
    logic              ovf_q;

    logic              fire;
    logic              tracking;
    logic              beat;
    logic              refract_ok;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] interval;

    assign fire     = ENABLE & SAMPLE_VLD;
    assign tracking = (state_q == ST_LOW) || (state_q == ST_HIGH);

    always_comb begin
        state_d = state_q;
        beat    = 1'b0;
        if (!ENABLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                // wait for a low sample so a start mid-pulse never counts as a beat
                ST_ARM:  if (SAMPLE_VLD && (SAMPLE < THRESH_LO)) state_d = ST_LOW;
                ST_LOW:  if (SAMPLE_VLD && (SAMPLE >= THRESH_HI) && refract_ok) begin
                             state_d = ST_HIGH;
                             beat    = 1'b1;
                         end
                ST_HIGH: if (SAMPLE_VLD && (SAMPLE < THRESH_LO)) state_d = ST_LOW;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    beat_interval_logger_sat_counter #(.W(DATA_W), .DOWN(1'b0)) u_interval_cnt (
        .CLK        (CLK),
        .RESET      (RESET),
        .clr_i      (!ENABLE || beat),
        .load_i     (1'b0),
        .load_val_i ('0),
        .step_i     (fire && tracking && have_prev_q && !beat),
        .value_o    (count)
    );

    // the beat sample itself completes the interval, hence count + 1
    assign interval = (count == INTERVAL_MAX) ? INTERVAL_MAX : count + DATA_ONE;

`ifdef BEAT_REFRACTORY_EN
    logic [DATA_W-1:0] refract_left;

    beat_interval_logger_sat_counter #(.W(DATA_W), .DOWN(1'b1)) u_refract_cnt (
        .CLK        (CLK),
        .RESET      (RESET),
        .clr_i      (!ENABLE),
        .load_i     (beat),
        .load_val_i (DATA_W'(REFRACT_SAMPLES)),
        .step_i     (fire),
        .value_o    (refract_left)
    );

    assign refract_ok = (refract_left == '0);
`else
    logic unused_refract;

    assign unused_refract = (REFRACT_SAMPLES != 0);
    assign refract_ok     = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            have_prev_q <= 1'b0;
            wptr_q      <= '0;
            dr_q        <= '0;
            ld_q        <= 1'b0;
            dout_q      <= '0;
            beat_q      <= 1'b0;
            log_cnt_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= 1'b0;
            beat_q  <= beat;
            if (!ENABLE) begin
                have_prev_q <= 1'b0;
            end else if (beat) begin
                have_prev_q <= 1'b1;
                if (have_prev_q) begin
                    dout_q <= interval;
                    dr_q   <= wptr_q;
                    ld_q   <= 1'b1;
                    wptr_q <= wptr_q + ADDR_ONE;
                    if (log_cnt_q != LOG_DEPTH) log_cnt_q <= log_cnt_q + CNT_ONE;
                    if (interval == INTERVAL_MAX) ovf_q <= 1'b1;
                end
            end
        end
    end

    assign DR      = dr_q;
    assign LD      = ld_q;
    assign D_OUT   = dout_q;
    assign BEAT    = beat_q;
    assign LOG_CNT = log_cnt_q;
    assign OVF     = ovf_q;

endmodule
